// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and defaults for the interrupt controller
package irq_pkg;

    // Default number of interrupt sources.
    localparam int NSRC_DEFAULT = 4;

    // Request FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - one-bit synchroniser followed by a rising-edge detector
//
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears sync and history flops
//   din   - asynchronous level input
//   rise  - high for one cycle after the synchronised level goes 0 -> 1
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    // Because history is cleared by reset, a source still high after reset
    // is seen as a fresh edge.
    assign rise = sync[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - prioritised, non-nesting interrupt controller
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   irq_in         - asynchronous level sources, rising edge = event
//   en_we/en_wdata - enable register write strobe and data
//   int_ack        - CPU has taken the interrupt (honoured in REQ only)
//   int_done       - CPU return-from-interrupt (honoured in SERVICE only)
//   int_sig        - registered interrupt request
//   int_vec        - index of the requested / serviced source
//   pending        - pending-event register
//   en             - enable register
//   busy           - high while the CPU services an interrupt
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NSRC        = NSRC_DEFAULT,
    parameter int SYNC_STAGES = 2,
    localparam int VW         = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic            en_we,
    input  logic [NSRC-1:0] en_wdata,
    input  logic            int_ack,
    input  logic            int_done,
    output logic            int_sig,
    output logic [VW-1:0]   int_vec,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] en,
    output logic            busy
);

    irq_state_t      state, state_nx;
    logic [NSRC-1:0] rise_vec;
    logic [NSRC-1:0] ready;
    logic [VW-1:0]   sel_vec;
    logic            sig_nx;
    logic [VW-1:0]   vec_nx;
    logic            busy_nx;
    logic [NSRC-1:0] pend_nx;
    logic [NSRC-1:0] en_nx;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk  (clk),
            .rst  (rst),
            .din  (irq_in[g]),
            .rise (rise_vec[g])
        );
    end

    // Lowest enabled pending index wins; scanning downward lets the last
    // hit be the lowest index.
    always_comb begin
        ready   = pending & en;
        sel_vec = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_vec = VW'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        sig_nx   = int_sig;
        vec_nx   = int_vec;
        busy_nx  = busy;
        pend_nx  = pending;
        en_nx    = en_we ? en_wdata : en;

        case (state)
            ST_IDLE: begin
                if (|ready) begin
                    state_nx = ST_REQ;
                    sig_nx   = 1'b1;
                    vec_nx   = sel_vec;
                end
            end
            ST_REQ: begin
                // Request is frozen until acknowledged, whatever en or
                // pending do meanwhile.
                if (int_ack) begin
                    state_nx         = ST_SERVICE;
                    sig_nx           = 1'b0;
                    busy_nx          = 1'b1;
                    pend_nx[int_vec] = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (int_done) begin
                    state_nx = ST_IDLE;
                    busy_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                sig_nx   = 1'b0;
                busy_nx  = 1'b0;
            end
        endcase

        // Applied after the ack clear so a coincident new event survives.
        pend_nx = pend_nx | rise_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            int_sig <= 1'b0;
            int_vec <= '0;
            busy    <= 1'b0;
            pending <= '0;
            en      <= '0;
        end else begin
            state   <= state_nx;
            int_sig <= sig_nx;
            int_vec <= vec_nx;
            busy    <= busy_nx;
            pending <= pend_nx;
            en      <= en_nx;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic       en_we;
    logic [3:0] en_wdata;
    logic       int_ack;
    logic       int_done;
    logic       int_sig;
    logic [1:0] int_vec;
    logic [3:0] pending;
    logic [3:0] en;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    irq_ctrl #(
        .NSRC(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .en_we    (en_we),
        .en_wdata (en_wdata),
        .int_ack  (int_ack),
        .int_done (int_done),
        .int_sig  (int_sig),
        .int_vec  (int_vec),
        .pending  (pending),
        .en       (en),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_en(input logic [3:0] v);
        en_we    = 1'b1;
        en_wdata = v;
        tick();
        en_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    // Pop the next expected vector and compare against the live request.
    task automatic pop_check(input string tag);
        int e;
        check_eq({tag, "_sig"}, 32'(int_sig), 32'd1);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_vec"}, 32'(int_vec), 32'(e));
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!int_sig && n < 20) begin
            tick();
            n++;
        end
        if (!int_sig) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        else          pop_check(tag);
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; en_we = 1'b0; en_wdata = '0;
        int_ack = 1'b0; int_done = 1'b0;
        tick(2);
        rst = 1'b0;
        check_eq("rst_sig", 32'(int_sig), 32'd0);
        check_eq("rst_vec", 32'(int_vec), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_pend", 32'(pending), 32'd0);
        check_eq("rst_en", 32'(en), 32'd0);

        // Exact latency: source 2 alone.
        write_en(4'hF);
        check_eq("en_f", 32'(en), 32'hF);
        irq_in = 4'b0100;
        tick(2);
        check_eq("lat_pend_k1", 32'(pending), 32'h0);
        tick();
        check_eq("lat_pend_k2", 32'(pending), 32'h4);
        check_eq("lat_sig_k2", 32'(int_sig), 32'd0);
        exp_q.push_back(2);
        tick();
        pop_check("lat_k3");

        // Ack, then event on source 0 during SERVICE stays parked.
        pulse_ack();
        check_eq("ack_busy", 32'(busy), 32'd1);
        check_eq("ack_sig", 32'(int_sig), 32'd0);
        check_eq("ack_pend", 32'(pending), 32'h0);
        irq_in = 4'b0101;
        tick(3);
        check_eq("svc_pend", 32'(pending), 32'h1);
        check_eq("svc_sig", 32'(int_sig), 32'd0);
        pulse_done();
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_sig", 32'(int_sig), 32'd0);
        exp_q.push_back(0);
        tick();
        pop_check("gap1");
        pulse_done();
        check_eq("req_done_ign_sig", 32'(int_sig), 32'd1);
        check_eq("req_done_ign_busy", 32'(busy), 32'd0);
        check_eq("req_done_ign_vec", 32'(int_vec), 32'd0);
        pulse_ack();
        pulse_done();
        irq_in = 4'b0000;
        tick(3);

        // Two sources together: lowest index first, then the other.
        irq_in = 4'b1010;
        exp_q.push_back(1);
        wait_req("pri1");
        pulse_ack();
        check_eq("pri_pend", 32'(pending), 32'h8);
        pulse_done();
        exp_q.push_back(3);
        wait_req("pri3");

        // Request frozen in REQ despite new higher-priority event and en=0.
        irq_in = 4'b1011;
        write_en(4'h0);
        tick(3);
        check_eq("hold_sig", 32'(int_sig), 32'd1);
        check_eq("hold_vec", 32'(int_vec), 32'd3);
        check_eq("hold_pend", 32'(pending), 32'h9);
        pulse_ack();
        check_eq("hold_ack_pend", 32'(pending), 32'h1);
        pulse_done();
        tick(3);
        check_eq("dis_sig", 32'(int_sig), 32'd0);
        check_eq("dis_pend", 32'(pending), 32'h1);
        write_en(4'hF);
        exp_q.push_back(0);
        wait_req("reen0");
        pulse_ack();
        pulse_done();
        irq_in = 4'b0000;
        tick(3);

        // Masked source becomes visible once enabled; stray ack ignored.
        write_en(4'b0001);
        irq_in = 4'b0100;
        tick(4);
        check_eq("mask_pend", 32'(pending), 32'h4);
        check_eq("mask_sig", 32'(int_sig), 32'd0);
        pulse_ack();
        check_eq("idle_ack_busy", 32'(busy), 32'd0);
        check_eq("idle_ack_pend", 32'(pending), 32'h4);
        write_en(4'b0100);
        check_eq("en_wr_sig", 32'(int_sig), 32'd0);
        exp_q.push_back(2);
        tick();
        pop_check("en_wr");
        pulse_ack();
        pulse_done();

        // Re-edge on source 3 coincident with its ack: set wins.
        write_en(4'hF);
        irq_in = 4'b1000;
        exp_q.push_back(3);
        wait_req("re3");
        irq_in = 4'b0000;
        tick(3);
        irq_in = 4'b1000;
        tick(2);
        pulse_ack();
        check_eq("setwin_pend", 32'(pending), 32'h8);
        check_eq("setwin_busy", 32'(busy), 32'd1);
        check_eq("setwin_sig", 32'(int_sig), 32'd0);
        pulse_done();
        check_eq("setwin_idle_sig", 32'(int_sig), 32'd0);
        exp_q.push_back(3);
        tick();
        pop_check("setwin_re");

        // Reset during SERVICE with source 0 held high.
        pulse_ack();
        irq_in = 4'b0001;
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_sig", 32'(int_sig), 32'd0);
        check_eq("mid_rst_vec", 32'(int_vec), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_pend", 32'(pending), 32'd0);
        check_eq("mid_rst_en", 32'(en), 32'd0);
        write_en(4'b0001);
        tick(2);
        check_eq("post_rst_pend", 32'(pending), 32'h1);
        check_eq("post_rst_sig3", 32'(int_sig), 32'd0);
        exp_q.push_back(0);
        tick();
        pop_check("post_rst");

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
